// File: rtl/barcode_pkg.sv
// barcode_pkg: shared state encoding, frame constants and value table for the barcode sequencer
package barcode_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} stateT;
   localparam int FRAME_LEN = 10;
   localparam logic [1:0] START = 2'b10;
   localparam logic [1:0] STOP = 2'b01;
   // Bit n set means value n is payable: 2..16 even, then 20, 24, 28
   localparam logic [31:0] VALID_MASK = 32'h1111_5554;
   localparam logic [4:0] P_LO = 5'd10;
   localparam logic [4:0] P_HI = 5'd16;
   localparam logic [4:0] P_OFF = 5'd20;
endpackage

// File: rtl/barcode_check_bit.sv
// barcode_check_bit: combinational value -> {valid, check bit} lookup
module barcode_check_bit
   import barcode_pkg::*;
(
   input logic [4:0] value,
   output logic valid,
   output logic p
);
   assign valid = VALID_MASK[value];
   assign p = value >= P_LO && value <= P_HI;
endmodule

// File: rtl/barcode_sequencer.sv
// barcode_sequencer: arbitrates two terminals, validates the value and serialises a 10-bit barcode frame.
// Define FRAME_COUNT_EN to add the frameCount output counting completed frames.
module barcode_sequencer
   import barcode_pkg::*;
#(
   parameter int BIT_CYCLES = 2,
   parameter int GAP_CYCLES = 4
) (
   input logic clk,
   input logic reset,
   input logic reqA,
   input logic [4:0] valueA,
   input logic reqB,
   input logic [4:0] valueB,
   output logic ackA,
   output logic ackB,
   output logic reject,
   output logic busy,
   output logic barValid,
`ifdef FRAME_COUNT_EN
   output logic [7:0] frameCount,
`endif
   output logic barBit
);
   localparam logic [3:0] BIT_LAST = 4'(BIT_CYCLES - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
   localparam logic [3:0] IDX_LAST = 4'(FRAME_LEN - 1);
   stateT state, nextState;
   logic lastB, nextLastB, granteeB, nextGranteeB, pickB;
   logic [4:0] val, nextVal;
   logic [3:0] bitIdx, nextBitIdx, cyc, nextCyc;
   logic valid, p;
   logic [9:0] frame;
   barcode_check_bit checkBit (.value(val), .valid(valid), .p(p));
   assign frame = {START, val, p, STOP};
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         lastB <= 1'b1;
         granteeB <= 1'b0;
         val <= '0;
         bitIdx <= '0;
         cyc <= '0;
      end else begin
         state <= nextState;
         lastB <= nextLastB;
         granteeB <= nextGranteeB;
         val <= nextVal;
         bitIdx <= nextBitIdx;
         cyc <= nextCyc;
      end
   end
   always_comb begin
      pickB = reqB & (~reqA | ~lastB);
      nextState = state;
      nextLastB = lastB;
      nextGranteeB = granteeB;
      nextVal = val;
      nextBitIdx = bitIdx;
      nextCyc = cyc;
      case (state)
         IDLE: if (reqA | reqB) begin
            nextState = LOAD;
            nextGranteeB = pickB;
            nextLastB = pickB;
            nextVal = pickB ? valueB : valueA;
         end
         LOAD: begin
            nextState = valid ? SEND : IDLE;
            nextBitIdx = '0;
            nextCyc = '0;
         end
         SEND: if (cyc != BIT_LAST) nextCyc = cyc + 4'd1;
         else begin
            nextCyc = '0;
            if (bitIdx == IDX_LAST) nextState = GAP;
            else nextBitIdx = bitIdx + 4'd1;
         end
         GAP: if (cyc != GAP_LAST) nextCyc = cyc + 4'd1;
         else nextState = IDLE;
         default: nextState = IDLE;
      endcase
      ackA = state == LOAD && !granteeB;
      ackB = state == LOAD && granteeB;
      reject = state == LOAD && !valid;
      busy = state != IDLE;
      barValid = state == SEND;
      barBit = state == SEND ? frame[IDX_LAST - bitIdx] : 1'b0;
   end
`ifdef FRAME_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) frameCount <= '0;
      else if (state == SEND && nextState == GAP) frameCount <= frameCount + 8'd1;
   end
`endif
endmodule
